// File: rtl/tcdm_bank_arb.sv
// ---------------------------------------------------------------------------
// tcdm_bank_arb
//
// Shares one single-ported TCDM bank between NumReq requesters. The
// lowest-index request wins, with optional aging that bounds how long a
// low-priority requester can wait. The bank's one-cycle read response is
// returned to whichever requester was granted.
//
// Optional feature macro: TCDM_ARB_AGING_EN
//   defined   -> per-requester aging counters. A requester that has been
//                denied StarveThr times in a row is "starved". Starved
//                requesters take precedence over all others, and the
//                lowest starved index wins.
//   undefined -> pure fixed priority. No counters are built and StarveThr
//                is only range-checked.
//
// Ports
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   req_i    : per-requester request valid
//   data_i   : per-requester payload {wen, be, addr, wdata}, not interpreted
//   gnt_o    : one-hot grant, or all-zero when idle (combinational)
//   rvld_o   : one-hot response valid, one cycle after the grant
//   rdata_o  : bank read data broadcast to all requesters (combinational)
//   idx_o    : index of the granted requester, 0 when idle (combinational)
//   cs_o     : bank chip select (combinational)
//   data_o   : payload forwarded to the bank (combinational)
//   rdata_i  : bank read data, valid one cycle after cs_o
// ---------------------------------------------------------------------------
module tcdm_bank_arb #(
  parameter int unsigned NumReq        = 4,
  parameter int unsigned ReqDataWidth  = 49,
  parameter int unsigned RespDataWidth = 32,
  parameter int unsigned StarveThr     = 15
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NumReq-1:0]                      req_i,
  input  logic [NumReq-1:0][ReqDataWidth-1:0]    data_i,
  output logic [NumReq-1:0]                      gnt_o,
  output logic [NumReq-1:0]                      rvld_o,
  output logic [RespDataWidth-1:0]               rdata_o,
  output logic [$clog2(NumReq)-1:0]              idx_o,
  output logic                                   cs_o,
  output logic [ReqDataWidth-1:0]                data_o,
  input  logic [RespDataWidth-1:0]               rdata_i
);

  localparam int unsigned IdxW = $clog2(NumReq);

  // Reject configurations the arbiter cannot honour at elaboration time.
  if (NumReq < 2) begin : g_bad_numreq
    $error("tcdm_bank_arb: NumReq must be at least 2");
  end
  if (StarveThr < 1) begin : g_bad_thr
    $error("tcdm_bank_arb: StarveThr must be at least 1");
  end

  // Candidate set handed to the priority encoder.
  logic [NumReq-1:0] cand;

`ifdef TCDM_ARB_AGING_EN
  localparam int unsigned CntW = $clog2(StarveThr + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(StarveThr);

  logic [CntW-1:0]   cnt_q [NumReq];
  logic [NumReq-1:0] starved;

  // A starved requester only counts while it is actually requesting. If
  // any requester is starved, the non-starved ones are masked out so the
  // starved set drains in index order.
  always_comb begin
    starved = '0;
    for (int i = 0; i < NumReq; i++) begin
      starved[i] = req_i[i] && (cnt_q[i] == CntMax);
    end
    cand = (|starved) ? starved : req_i;
  end

  // The counter saturates at StarveThr while the requester is denied. It
  // clears on a grant or when the request is dropped, so a dropped request
  // forfeits its accumulated age.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumReq; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NumReq; i++) begin
        if (req_i[i] && !gnt_o[i]) begin
          if (cnt_q[i] != CntMax) begin
            cnt_q[i] <= cnt_q[i] + CntW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end
`else
  assign cand = req_i;
`endif

  // Lowest-index candidate wins. Both outputs stay zero when idle.
  always_comb begin
    logic found;
    found = 1'b0;
    gnt_o = '0;
    idx_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (cand[i] && !found) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IdxW'(i);
      end
    end
  end

  // The bank is always ready, so any request means an access this cycle.
  assign cs_o   = |req_i;
  assign data_o = data_i[idx_o];

  // Response path: the bank answers one cycle after cs_o. Remembering the
  // grant for that one cycle is enough to steer the response. Reset clears
  // the register, so any in-flight response is discarded.
  logic [NumReq-1:0] rvld_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvld_q <= '0;
    end else begin
      rvld_q <= gnt_o;
    end
  end

  assign rvld_o  = rvld_q;
  assign rdata_o = rdata_i;

endmodule

// File: tb/tb_tcdm_bank_arb.sv
// ---------------------------------------------------------------------------
// tb_tcdm_bank_arb
//
// Bench for tcdm_bank_arb with NumReq=4 and StarveThr=3. A stimulus process
// drives one cycle at a time. For each cycle it pushes the expected
// combinational outputs, and the expected response of the grant, into
// scoreboard queues. A monitor process samples on the falling edge and pops
// and compares those entries. The expected grants come from fixed
// sequences for the directed scenarios, and from an age-based reference
// model for the random traffic.
// ---------------------------------------------------------------------------
module tb_tcdm_bank_arb;

  localparam int N   = 4;
  localparam int DW  = 49;
  localparam int RW  = 32;
  localparam int THR = 3;

  logic                   clk = 1'b0;
  logic                   rst_ni;
  logic [N-1:0]           req;
  logic [N-1:0][DW-1:0]   data;
  logic [N-1:0]           gnt;
  logic [N-1:0]           rvld;
  logic [RW-1:0]          rdata_o;
  logic [1:0]             idx;
  logic                   cs;
  logic [DW-1:0]          data_o;
  logic [RW-1:0]          rdata_i;

  tcdm_bank_arb #(
    .NumReq       (N),
    .ReqDataWidth (DW),
    .RespDataWidth(RW),
    .StarveThr    (THR)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .req_i  (req),
    .data_i (data),
    .gnt_o  (gnt),
    .rvld_o (rvld),
    .rdata_o(rdata_o),
    .idx_o  (idx),
    .cs_o   (cs),
    .data_o (data_o),
    .rdata_i(rdata_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int            due;
    logic [N-1:0]  gnt;
    int            idx;
    logic          cs;
    logic [DW-1:0] data;
  } comb_t;

  typedef struct {
    int            due;
    logic [N-1:0]  vld;
    logic [RW-1:0] rdata;
  } rsp_t;

  comb_t comb_q[$];
  rsp_t  rsp_q[$];

  int checks = 0;
  int passed = 0;

  // Reference state: consecutive denied cycles per requester.
  int ages[N];
  logic [RW-1:0] rd_next;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Winner chosen from the rules: starved requesters first, by index;
  // otherwise the lowest requesting index. Returns -1 when idle.
  function automatic int model_pick(input logic [N-1:0] r);
    int w;
    w = -1;
`ifdef TCDM_ARB_AGING_EN
    for (int i = 0; i < N; i++) if (r[i] && ages[i] >= THR && w < 0) w = i;
`endif
    for (int i = 0; i < N; i++) if (r[i] && w < 0) w = i;
    return w;
  endfunction

  // Drive one cycle. An exp_idx of -2 means "use the model"; any other
  // value is the grant index required by a directed sequence.
  task automatic step(input logic rst, input logic [N-1:0] r, input int exp_idx,
                      input logic [RW-1:0] rd_for_next);
    int    m;
    int    e;
    comb_t ce;
    rsp_t  re;
    @(posedge clk);
    #1;
    rst_ni = rst;
    req    = r;
    for (int i = 0; i < N; i++) data[i] = DW'({$urandom(), $urandom()});
    rdata_i = rd_next;
    rd_next = rd_for_next;
    if (!rst) for (int i = 0; i < N; i++) ages[i] = 0;
    m = model_pick(r);
    e = (exp_idx == -2) ? m : exp_idx;
    ce.due  = cyc;
    ce.cs   = |r;
    ce.gnt  = '0;
    if (e >= 0) ce.gnt[e] = 1'b1;
    ce.idx  = (e >= 0) ? e : 0;
    ce.data = (e >= 0) ? data[e] : data[0];
    comb_q.push_back(ce);
    if (rst && e >= 0) begin
      re.due   = cyc + 1;
      re.vld   = ce.gnt;
      re.rdata = rd_next;
      rsp_q.push_back(re);
    end
    for (int i = 0; i < N; i++) begin
      if (!rst) ages[i] = 0;
      else if (r[i] && i != m) ages[i] = (ages[i] + 1 > THR) ? THR : ages[i] + 1;
      else ages[i] = 0;
    end
  endtask

  // Monitor: compare what the DUT presents against the scoreboard.
  always @(negedge clk) begin
    comb_t ce;
    rsp_t  re;
    if (comb_q.size() > 0 && comb_q[0].due == cyc) begin
      ce = comb_q.pop_front();
      check("gnt", 64'(gnt), 64'(ce.gnt));
      check("idx", 64'(idx), 64'(ce.idx));
      check("cs", 64'(cs), 64'(ce.cs));
      if (ce.cs) check("data_o", 64'(data_o), 64'(ce.data));
    end
    if (!rst_ni) begin
      while (rsp_q.size() > 0 && rsp_q[0].due <= cyc) re = rsp_q.pop_front();
      check("rvld_in_reset", 64'(rvld), 64'd0);
    end else if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      re = rsp_q.pop_front();
      check("rvld", 64'(rvld), 64'(re.vld));
      check("rdata", 64'(rdata_o), 64'(re.rdata));
    end else begin
      check("rvld_idle", 64'(rvld), 64'd0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int seq_age[8];
    int seq_sim[7];
    int seq_drop[7];
    logic [N-1:0] drop_req[7];
    logic [N-1:0] r;
`ifdef TCDM_ARB_AGING_EN
    seq_age  = '{0, 0, 0, 3, 0, 0, 0, 3};
    seq_sim  = '{0, 0, 0, 1, 2, 3, 0};
    seq_drop = '{0, 0, 0, 0, 0, 0, 3};
`else
    seq_age  = '{0, 0, 0, 0, 0, 0, 0, 0};
    seq_sim  = '{0, 0, 0, 0, 0, 0, 0};
    seq_drop = '{0, 0, 0, 0, 0, 0, 0};
`endif
    drop_req = '{4'b1001, 4'b1001, 4'b0001, 4'b1001, 4'b1001, 4'b1001, 4'b1001};
    for (int i = 0; i < N; i++) ages[i] = 0;
    rst_ni  = 1'b0;
    req     = '0;
    data    = '0;
    rdata_i = '0;
    rd_next = '0;

    // Reset with all requesting: combinational grant to 0, no responses.
    step(1'b0, 4'b1111, 0, $urandom());
    step(1'b0, 4'b1111, 0, $urandom());
    step(1'b1, 4'b0000, -1, $urandom());
    step(1'b1, 4'b0000, -1, $urandom());

    // Priority and one-cycle latency.
    step(1'b1, 4'b0110, 1, 32'hCAFE0001);
    step(1'b1, 4'b0000, -1, $urandom());

    // Aging against a permanent high-priority requester.
    for (int k = 0; k < 8; k++) step(1'b1, 4'b1001, seq_age[k], $urandom());
    step(1'b1, 4'b0000, -1, $urandom());

    // Simultaneous starvation drains in index order.
    for (int k = 0; k < 7; k++) step(1'b1, 4'b1111, seq_sim[k], $urandom());
    step(1'b1, 4'b0000, -1, $urandom());

    // A dropped request loses its age.
    for (int k = 0; k < 7; k++) step(1'b1, drop_req[k], seq_drop[k], $urandom());
    step(1'b1, 4'b0000, -1, $urandom());

    // Reset mid-operation discards the pending response and the grant
    // made during reset.
    step(1'b1, 4'b0001, 0, $urandom());
    step(1'b0, 4'b0010, 1, $urandom());
    step(1'b1, 4'b0000, -1, $urandom());

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      r = N'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) r[3] = 1'b1;
      step(($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1, r, -2, $urandom());
    end

    for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, -1, $urandom());
    @(posedge clk);
    #1;
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
    check("comb_queue_drained", 64'(comb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
